// File: rtl/cache_arbiter_pkg.sv
// Shared definitions for the cache arbiter slice.
//   - state_t / ST_* : arbiter FSM state encoding
//   - port_sel_e     : which requester port owns the current access
//   - TIMEOUT_DEF    : default memory-side cycle budget per access
//   - CNT_W          : width of the BUSY cycle counter (covers TIMEOUT up to 255)
//   - helper functions shared by the top level
package cache_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef enum logic {
    SEL_D = 1'b0,
    SEL_I = 1'b1
  } port_sel_e;

  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;

  // Word-aligned when the two byte-offset bits are zero.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

  // Data word returned to the requester: only a completed read carries data.
  function automatic logic [31:0] resp_word(input logic        abort,
                                            input logic        wr,
                                            input logic [31:0] rdata);
    return (abort || wr) ? 32'd0 : rdata;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker.
//   req_d, req_i : request from data / instruction port
//   last_sel     : port granted most recently
//   grant_vld    : at least one request present
//   grant_sel    : port chosen; on a tie the port not granted last wins
module arb_rr2
  import cache_arbiter_pkg::*;
(
  input  logic      req_d,
  input  logic      req_i,
  input  port_sel_e last_sel,
  output logic      grant_vld,
  output port_sel_e grant_sel
);

  always_comb begin
    grant_vld = req_d | req_i;
    grant_sel = SEL_D;
    if (req_i && (!req_d || (last_sel == SEL_D))) begin
      grant_sel = SEL_I;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates a data port and an instruction port onto one shared memory
// interface, one access outstanding at a time.
//   i_clk, i_reset_n            : clock, asynchronous active-low reset
//   i_d_rd_en/i_d_wr_en         : data read/write request (both high = write)
//   i_d_address, i_d_data       : data address / write data
//   o_d_data, o_d_ack, o_d_abort: data read result, completion, abort flag
//   i_i_rd_en, i_i_address      : instruction fetch request / address
//   o_i_data, o_i_ack, o_i_abort: fetch result, completion, abort flag
//   o_m_req, o_m_wr, o_m_address, o_m_wdata : shared memory command
//   i_m_rdata, i_m_ack          : memory read data / completion
// Parameter TIMEOUT (2..255): memory cycles allowed before the access aborts.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_d_rd_en,
  input  logic        i_d_wr_en,
  input  logic [31:0] i_d_address,
  input  logic [31:0] i_d_data,
  output logic [31:0] o_d_data,
  output logic        o_d_ack,
  output logic        o_d_abort,
  input  logic        i_i_rd_en,
  input  logic [31:0] i_i_address,
  output logic [31:0] o_i_data,
  output logic        o_i_ack,
  output logic        o_i_abort,
  output logic        o_m_req,
  output logic        o_m_wr,
  output logic [31:0] o_m_address,
  output logic [31:0] o_m_wdata,
  input  logic [31:0] i_m_rdata,
  input  logic        i_m_ack
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  port_sel_e        sel_q;
  port_sel_e        last_sel_q;
  logic             wr_q;
  logic             abort_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      m_addr_q;
  logic [31:0]      m_wdata_q;
  logic [31:0]      d_data_q;
  logic [31:0]      i_data_q;

  logic             d_req;
  logic             grant_vld;
  port_sel_e        grant_sel;
  logic [31:0]      g_addr;
  logic             g_wr;
  logic [31:0]      g_wdata;
  logic             g_aligned;

  logic             resp_enter;
  port_sel_e        resp_sel;
  logic             resp_abort;
  logic [31:0]      resp_data;

  assign d_req = i_d_rd_en | i_d_wr_en;

  arb_rr2 u_arb (
    .req_d     (d_req),
    .req_i     (i_i_rd_en),
    .last_sel  (last_sel_q),
    .grant_vld (grant_vld),
    .grant_sel (grant_sel)
  );

  // Command fields of the granted port; the instruction port only reads.
  always_comb begin
    g_addr    = (grant_sel == SEL_D) ? i_d_address : i_i_address;
    g_wr      = (grant_sel == SEL_D) & i_d_wr_en;
    g_wdata   = g_wr ? i_d_data : 32'd0;
    g_aligned = is_aligned(g_addr[1:0]);
  end

  // Decide whether this cycle ends the access and with what outcome.
  // A memory ack in the final budgeted cycle still counts as success.
  always_comb begin
    resp_enter = 1'b0;
    resp_sel   = sel_q;
    resp_abort = 1'b0;
    resp_data  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld && !g_aligned) begin
          resp_enter = 1'b1;
          resp_sel   = grant_sel;
          resp_abort = 1'b1;
        end
      end
      ST_BUSY: begin
        if (i_m_ack) begin
          resp_enter = 1'b1;
          resp_data  = resp_word(1'b0, wr_q, i_m_rdata);
        end else if (cnt_q == TO_LAST) begin
          resp_enter = 1'b1;
          resp_abort = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered state: FSM, command, counter and per-port result registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_D;
      last_sel_q <= SEL_I;
      wr_q       <= 1'b0;
      abort_q    <= 1'b0;
      cnt_q      <= '0;
      m_addr_q   <= 32'd0;
      m_wdata_q  <= 32'd0;
      d_data_q   <= 32'd0;
      i_data_q   <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            sel_q      <= grant_sel;
            last_sel_q <= grant_sel;
            wr_q       <= g_wr;
            if (g_aligned) begin
              state_q   <= ST_BUSY;
              m_addr_q  <= g_addr;
              m_wdata_q <= g_wdata;
              cnt_q     <= '0;
            end else begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          if (resp_enter) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (resp_enter) begin
        abort_q <= resp_abort;
        if (resp_sel == SEL_D) begin
          d_data_q <= resp_data;
        end else begin
          i_data_q <= resp_data;
        end
      end
    end
  end

  // Request and ack are decoded from the state register so a reset
  // removes them immediately, without waiting for a clock edge.
  assign o_m_req     = (state_q == ST_BUSY);
  assign o_m_wr      = wr_q & o_m_req;
  assign o_m_address = m_addr_q;
  assign o_m_wdata   = m_wdata_q;

  assign o_d_ack     = (state_q == ST_RESP) && (sel_q == SEL_D);
  assign o_i_ack     = (state_q == ST_RESP) && (sel_q == SEL_I);
  assign o_d_abort   = o_d_ack & abort_q;
  assign o_i_abort   = o_i_ack & abort_q;
  assign o_d_data    = d_data_q;
  assign o_i_data    = i_data_q;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_d_rd_en, i_d_wr_en;
  logic [31:0] i_d_address, i_d_data;
  logic [31:0] o_d_data;
  logic        o_d_ack, o_d_abort;
  logic        i_i_rd_en;
  logic [31:0] i_i_address;
  logic [31:0] o_i_data;
  logic        o_i_ack, o_i_abort;
  logic        o_m_req, o_m_wr;
  logic [31:0] o_m_address, o_m_wdata;
  logic [31:0] i_m_rdata;
  logic        i_m_ack;

  int errors = 0;
  int checks = 0;

  cache_arbiter #(.TIMEOUT(4)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_d_rd_en   (i_d_rd_en),
    .i_d_wr_en   (i_d_wr_en),
    .i_d_address (i_d_address),
    .i_d_data    (i_d_data),
    .o_d_data    (o_d_data),
    .o_d_ack     (o_d_ack),
    .o_d_abort   (o_d_abort),
    .i_i_rd_en   (i_i_rd_en),
    .i_i_address (i_i_address),
    .o_i_data    (o_i_data),
    .o_i_ack     (o_i_ack),
    .o_i_abort   (o_i_abort),
    .o_m_req     (o_m_req),
    .o_m_wr      (o_m_wr),
    .o_m_address (o_m_address),
    .o_m_wdata   (o_m_wdata),
    .i_m_rdata   (i_m_rdata),
    .i_m_ack     (i_m_ack)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_d_rd_en = 1'b0; i_d_wr_en = 1'b0; i_d_address = 32'd0; i_d_data = 32'd0;
    i_i_rd_en = 1'b0; i_i_address = 32'd0;
    i_m_rdata = 32'd0; i_m_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset_n = 1'b0;
    tick(); tick();
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset_n = 1'b0;
    tick();
    checks++; if (o_m_req !== 1'b0) begin errors++; $display("FAIL rst_m_req: got %0b want 0", o_m_req); end
    checks++; if (o_d_ack !== 1'b0 || o_i_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got d=%0b i=%0b want 0 0", o_d_ack, o_i_ack); end
    checks++; if (o_d_data !== 32'd0 || o_i_data !== 32'd0) begin errors++; $display("FAIL rst_data: got d=%h i=%h want 0 0", o_d_data, o_i_data); end
    checks++; if (o_m_address !== 32'd0 || o_m_wdata !== 32'd0 || o_m_wr !== 1'b0) begin errors++; $display("FAIL rst_cmd: got a=%h w=%h wr=%0b want 0", o_m_address, o_m_wdata, o_m_wr); end
    i_reset_n = 1'b1;
    tick();
  endtask

  // Both ports pending from reset: data first, then instruction, then data again
  // (the re-raised data request must lose the tie to the waiting fetch).
  task automatic test_both();
    do_reset();
    i_d_rd_en = 1'b1; i_d_address = 32'h200;
    i_i_rd_en = 1'b1; i_i_address = 32'h0;
    tick();
    checks++; if (o_m_req !== 1'b1 || o_m_address !== 32'h200) begin errors++; $display("FAIL both_first: got req=%0b a=%h want 1 00000200", o_m_req, o_m_address); end
    i_m_ack = 1'b1; i_m_rdata = 32'hA5A5_0001;
    tick();
    checks++; if (o_d_ack !== 1'b1 || o_i_ack !== 1'b0 || o_m_req !== 1'b0) begin errors++; $display("FAIL both_d_ack: got d=%0b i=%0b req=%0b want 1 0 0", o_d_ack, o_i_ack, o_m_req); end
    checks++; if (o_d_data !== 32'hA5A5_0001) begin errors++; $display("FAIL both_d_data: got %h want a5a50001", o_d_data); end
    i_m_ack = 1'b0;
    i_d_address = 32'h204;
    tick();
    checks++; if (o_m_req !== 1'b0 || o_d_ack !== 1'b0 || o_i_ack !== 1'b0) begin errors++; $display("FAIL both_gap: got req=%0b d=%0b i=%0b want 0 0 0", o_m_req, o_d_ack, o_i_ack); end
    tick();
    checks++; if (o_m_req !== 1'b1 || o_m_address !== 32'h0) begin errors++; $display("FAIL both_rr_i: got req=%0b a=%h want 1 00000000", o_m_req, o_m_address); end
    i_m_ack = 1'b1; i_m_rdata = 32'h0BAD_F00D;
    tick();
    checks++; if (o_i_ack !== 1'b1 || o_d_ack !== 1'b0 || o_i_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL both_i_ack: got i=%0b d=%0b data=%h want 1 0 0badf00d", o_i_ack, o_d_ack, o_i_data); end
    i_m_ack = 1'b0; i_i_rd_en = 1'b0;
    tick();
    tick();
    checks++; if (o_m_req !== 1'b1 || o_m_address !== 32'h204) begin errors++; $display("FAIL both_third: got req=%0b a=%h want 1 00000204", o_m_req, o_m_address); end
    i_m_ack = 1'b1; i_m_rdata = 32'h3;
    tick();
    checks++; if (o_d_ack !== 1'b1 || o_d_data !== 32'h3) begin errors++; $display("FAIL both_d2: got ack=%0b data=%h want 1 00000003", o_d_ack, o_d_data); end
    clear_inputs();
    tick();
  endtask

  task automatic test_data_read();
    i_d_rd_en = 1'b1; i_d_address = 32'h100;
    tick();
    checks++; if (o_m_req !== 1'b1 || o_m_address !== 32'h100 || o_m_wr !== 1'b0) begin errors++; $display("FAIL rd_cmd: got req=%0b a=%h wr=%0b want 1 00000100 0", o_m_req, o_m_address, o_m_wr); end
    checks++; if (o_d_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack: got %0b want 0", o_d_ack); end
    i_m_ack = 1'b1; i_m_rdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (o_d_ack !== 1'b1 || o_d_abort !== 1'b0 || o_i_ack !== 1'b0) begin errors++; $display("FAIL rd_ack: got ack=%0b abort=%0b i=%0b want 1 0 0", o_d_ack, o_d_abort, o_i_ack); end
    checks++; if (o_d_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", o_d_data); end
    clear_inputs();
    tick();
    checks++; if (o_d_ack !== 1'b0 || o_d_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold: got ack=%0b data=%h want 0 deadbeef", o_d_ack, o_d_data); end
  endtask

  task automatic test_write();
    i_d_rd_en = 1'b1; i_d_wr_en = 1'b1; i_d_address = 32'h40; i_d_data = 32'h1234_5678;
    tick();
    checks++; if (o_m_req !== 1'b1 || o_m_wr !== 1'b1) begin errors++; $display("FAIL wr_cmd: got req=%0b wr=%0b want 1 1", o_m_req, o_m_wr); end
    checks++; if (o_m_wdata !== 32'h1234_5678 || o_m_address !== 32'h40) begin errors++; $display("FAIL wr_fields: got w=%h a=%h want 12345678 00000040", o_m_wdata, o_m_address); end
    i_m_ack = 1'b1; i_m_rdata = 32'hFFFF_FFFF;
    tick();
    checks++; if (o_d_ack !== 1'b1 || o_d_abort !== 1'b0 || o_d_data !== 32'd0) begin errors++; $display("FAIL wr_ack: got ack=%0b abort=%0b data=%h want 1 0 00000000", o_d_ack, o_d_abort, o_d_data); end
    clear_inputs();
    tick();
  endtask

  task automatic test_misaligned();
    bit saw_req = 1'b0;
    i_i_rd_en = 1'b1; i_i_address = 32'h103;
    tick();
    saw_req = o_m_req;
    checks++; if (o_i_ack !== 1'b1 || o_i_abort !== 1'b1 || o_d_ack !== 1'b0) begin errors++; $display("FAIL mis_ack: got ack=%0b abort=%0b d=%0b want 1 1 0", o_i_ack, o_i_abort, o_d_ack); end
    checks++; if (o_i_data !== 32'd0) begin errors++; $display("FAIL mis_data: got %h want 00000000", o_i_data); end
    clear_inputs();
    tick();
    saw_req = saw_req | o_m_req;
    checks++; if (saw_req !== 1'b0 || o_i_ack !== 1'b0) begin errors++; $display("FAIL mis_no_req: got req_seen=%0b ack=%0b want 0 0", saw_req, o_i_ack); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    i_d_rd_en = 1'b1; i_d_address = 32'h300;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_m_req === 1'b1 && o_d_ack === 1'b0) req_cycles++;
    end
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
    tick();
    checks++; if (o_d_ack !== 1'b1 || o_d_abort !== 1'b1 || o_m_req !== 1'b0) begin errors++; $display("FAIL to_abort: got ack=%0b abort=%0b req=%0b want 1 1 0", o_d_ack, o_d_abort, o_m_req); end
    checks++; if (o_d_data !== 32'd0) begin errors++; $display("FAIL to_data: got %h want 00000000", o_d_data); end
    i_d_rd_en = 1'b0;
    i_m_ack = 1'b1; i_m_rdata = 32'hCAFE_CAFE;
    tick();
    tick();
    checks++; if (o_m_req !== 1'b0 || o_d_ack !== 1'b0 || o_i_ack !== 1'b0 || o_d_data !== 32'd0) begin errors++; $display("FAIL to_late_ack: got req=%0b d=%0b i=%0b data=%h want 0 0 0 0", o_m_req, o_d_ack, o_i_ack, o_d_data); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_busy();
    int acks = 0;
    i_d_rd_en = 1'b1; i_d_address = 32'h400;
    tick();
    checks++; if (o_m_req !== 1'b1) begin errors++; $display("FAIL rb_busy: got req=%0b want 1", o_m_req); end
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++; if (o_m_req !== 1'b0) begin errors++; $display("FAIL rb_async: got req=%0b want 0", o_m_req); end
    i_d_address = 32'h500;
    i_i_rd_en = 1'b1; i_i_address = 32'h600;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (o_d_ack === 1'b1 || o_i_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL rb_no_ack: got %0d acks want 0", acks); end
    i_reset_n = 1'b1;
    tick();
    checks++; if (o_m_req !== 1'b1 || o_m_address !== 32'h500) begin errors++; $display("FAIL rb_tie: got req=%0b a=%h want 1 00000500", o_m_req, o_m_address); end
    i_m_ack = 1'b1; i_m_rdata = 32'h5555_AAAA;
    tick();
    checks++; if (o_d_ack !== 1'b1 || o_i_ack !== 1'b0 || o_d_data !== 32'h5555_AAAA) begin errors++; $display("FAIL rb_ack: got d=%0b i=%0b data=%h want 1 0 5555aaaa", o_d_ack, o_i_ack, o_d_data); end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    i_reset_n = 1'b0;
    test_reset();
    test_both();
    test_data_read();
    test_write();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: memory-side cycles allowed per access before abort; legal range 2..255.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_d_rd_en / i_d_wr_en  input  1 each  data-port read / write request, level, held until ack.
REQ-005 i_d_address  input  32  data byte address; i_d_data  input  32  write data.
REQ-006 o_d_data  output  32  read data; o_d_ack  output  1  one-cycle completion; o_d_abort  output  1  qualifies ack as abort.
REQ-007 i_i_rd_en  input  1  instruction fetch request; i_i_address  input  32  fetch byte address.
REQ-008 o_i_data  output  32; o_i_ack  output  1; o_i_abort  output  1  (same meaning as data port).
REQ-009 o_m_req  output  1; o_m_wr  output  1; o_m_address  output  32; o_m_wdata  output  32  shared-memory command.
REQ-010 i_m_rdata  input  32; i_m_ack  input  1  memory completion, valid only while o_m_req=1.

Function
REQ-011 FSM states IDLE, BUSY, RESP; one access outstanding at most.
REQ-012 IDLE: sample requests; one requester -> grant it; both -> grant port not granted last (round-robin); none -> stay.
REQ-013 Data port with i_d_rd_en and i_d_wr_en both 1 SHALL be a write.
REQ-014 Granted address[1:0]!=0 -> IDLE to RESP directly with abort=1, no memory command.
REQ-015 Aligned grant -> BUSY next cycle: o_m_req=1, address/wdata/o_m_wr registered from granted port, held constant throughout BUSY.
REQ-016 BUSY with i_m_ack=1 -> RESP; read data captured from i_m_rdata that cycle.
REQ-017 BUSY cycle counter from 0; reaching TIMEOUT-1 without i_m_ack -> RESP with abort=1, o_m_req drops.
REQ-018 RESP lasts exactly one cycle: granted port's ack=1, abort per outcome, data valid for reads (0 on abort or write); then IDLE.
REQ-019 Latency: request seen in IDLE cycle N, memory acking first BUSY cycle -> ack in cycle N+2; minimum 2, maximum TIMEOUT+1.
REQ-020 Requests ignored in BUSY and RESP; request still high in IDLE after ack is a new request.
REQ-021 i_m_ack outside BUSY ignored; non-granted port's ack/abort stay 0.
REQ-022 o_d_data/o_i_data hold last value until next RESP for that port.

Reset
REQ-023 i_reset_n low: state IDLE, counter 0, all outputs 0, last-grant = instruction (data wins first tie).
REQ-024 Reset during BUSY/RESP abandons the access: no ack issued, o_m_req drops asynchronously.

Structure
REQ-025 Shared package holds state enum, port-select encoding and TIMEOUT default.
REQ-026 One sub-module arb_rr2: 2-way round-robin picker (two requests, last-grant in; grant out).

Verification
REQ-027 Data read 0x100, memory acks first BUSY cycle with 0xDEADBEEF -> o_d_ack+data 0xDEADBEEF two cycles after request, abort=0.
REQ-028 Both ports request from reset (d=0x200 read, i=0x0) -> data served first, then instruction; ack order d,i; no overlap of o_m_req.
REQ-029 Data write 0x40 value 0x12345678 with rd_en=1 also -> o_m_wr=1, o_m_wdata=0x12345678, o_d_data=0 at ack.
REQ-030 Fetch 0x103 -> o_i_ack=o_i_abort=1 one cycle after grant; o_m_req never asserted.
REQ-031 TIMEOUT=4, memory never acks -> o_m_req high 4 cycles, then o_d_ack=o_d_abort=1; late i_m_ack ignored.
REQ-032 Assert i_reset_n=0 mid-BUSY -> o_m_req=0 immediately, no ack; after release data port wins first tie.
